// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int STATE_W              = 3;
    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: combinational block assigns a default first so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a registered-output FWFT FIFO and
// serialises them as start, 8 data bits LSB first, optional even parity, stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        frame_count
);

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        bit_idx_q;
    logic              parity_q;
    logic              tx_q;
    logic [7:0]        frame_cnt_q;

    logic baud_clear;
    logic bit_tick;

    // The counter is held at zero while waiting, so every timed state is entered at count 0;
    // timed states only leave on a tick, where the counter wraps to zero by itself.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_SETTLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(baud_clear),
        .tick_o (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is a plain data register, reset anyway so tx never depends on stale data.
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ena && !fifo_empty) begin
                        state_q <= ST_SETTLE;
                    end
                end
                // SETTLE gives the FIFO output register one cycle to present the word.
                ST_SETTLE: begin
                    if (fifo_empty) begin
                        state_q <= ST_IDLE;
                    end else begin
                        shift_q   <= fifo_data;
                        parity_q  <= even_parity(fifo_data);
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // A drained FIFO during SETTLE must not see a pop.
    assign fifo_read   = (state_q == ST_SETTLE) && !fifo_empty;
    assign busy        = (state_q != ST_IDLE);
    assign tx          = tx_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two transmitters (parity off/on) fed by FWFT FIFO models,
// frames decoded cycle by cycle from tx and compared against queued bytes.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam bit PAR   = (c == 1);
        localparam int NBITS = PAR ? 11 : 10;

        logic [7:0] fifo_data;
        logic       fifo_empty = 1'b1;
        logic       fifo_read;
        logic       tx;
        logic       busy;
        logic [7:0] frame_count;

        logic [7:0] fq[$];
        logic [7:0] exp_q[$];

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PAR)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .fifo_data  (fifo_data),
            .fifo_empty (fifo_empty),
            .fifo_read  (fifo_read),
            .tx         (tx),
            .busy       (busy),
            .frame_count(frame_count)
        );

        // FIFO model: flags and data are registered from the pre-edge contents.
        bit rd_seen = 1'b0;
        always @(posedge clk) begin
            fifo_empty <= (fq.size() == 0);
            fifo_data  <= (fq.size() != 0) ? fq[0] : 8'($urandom);
            if (rd_seen && fq.size() != 0) void'(fq.pop_front());
        end

        int rd_cycles = 0;
        int starts    = 0;
        int done      = 0;
        int n_gap     = 0;
        int cyc       = 0;
        int hi_run    = 0;
        int last_len  = 0;
        int bad_cyc   = -1;
        bit active    = 1'b0;
        bit b2b       = 1'b0;
        logic [7:0]       cur = '0;
        logic [NBITS-1:0] bits = '1;

        always @(negedge clk) begin
            rd_seen = fifo_read;
            if (!rst_n) begin
                active = 1'b0;
                b2b    = 1'b0;
                hi_run = 0;
                done   = 0;
            end else begin
                if (fifo_read) rd_cycles++;
                if (active) begin
                    if (cyc < NBITS * CPB) begin
                        if (tx !== bits[cyc / CPB] && bad_cyc < 0) bad_cyc = cyc;
                        cyc++;
                    end else begin
                        done++;
                        active   = 1'b0;
                        last_len = cyc;
                        check($sformatf("ch%0d frame 0x%02h first wrong cycle", c, cur), bad_cyc, -1);
                        check($sformatf("ch%0d frame_count", c), int'(frame_count), done % 256);
                        check($sformatf("ch%0d {busy,tx} after stop", c), int'({busy, tx}), 1);
                        hi_run = 1;
                        b2b    = ena && !fifo_empty;
                    end
                end else if (tx === 1'b0) begin
                    starts++;
                    if (exp_q.size() == 0) begin
                        check($sformatf("ch%0d frame with no queued byte", c), 1, 0);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    bits    = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[1 + i] = cur[i];
                    if (PAR) bits[9] = ^cur;
                    if (b2b) begin
                        n_gap++;
                        check($sformatf("ch%0d idle-high gap", c), hi_run, 2);
                    end
                    active  = 1'b1;
                    cyc     = 1;
                    bad_cyc = -1;
                end else begin
                    hi_run++;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        g_ch[0].fq.push_back(b);
        g_ch[1].fq.push_back(b);
        g_ch[0].exp_q.push_back(b);
        g_ch[1].exp_q.push_back(b);
    endtask

    function automatic bit all_idle();
        return g_ch[0].fq.size() == 0 && g_ch[1].fq.size() == 0 &&
               g_ch[0].exp_q.size() == 0 && g_ch[1].exp_q.size() == 0 &&
               !g_ch[0].active && !g_ch[1].active &&
               g_ch[0].busy == 1'b0 && g_ch[1].busy == 1'b0;
    endfunction

    task automatic wait_idle(input int budget, input string what);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < budget && !all_idle());
        check({what, " drained within budget"}, int'(all_idle()), 1);
    endtask

    task automatic check_both(input string name, input int a0, input int a1, input int exp);
        check({"ch0 ", name}, a0, exp);
        check({"ch1 ", name}, a1, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, rd1, st0, st1, bad0, bad1, n_push, n;

        rst_n = 1'b0;
        ena   = 1'b0;
        repeat (3) @(negedge clk);
        check_both("reset tx", int'(g_ch[0].tx), int'(g_ch[1].tx), 1);
        check_both("reset busy", int'(g_ch[0].busy), int'(g_ch[1].busy), 0);
        check_both("reset fifo_read", int'(g_ch[0].fifo_read), int'(g_ch[1].fifo_read), 0);
        check_both("reset frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 0);
        rst_n = 1'b1;

        // Single byte 0xA5.
        push(8'hA5);
        ena = 1'b1;
        wait_idle(500, "A5");
        check_both("A5 frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 1);
        check_both("A5 pop cycles", g_ch[0].rd_cycles, g_ch[1].rd_cycles, 1);
        check("ch0 frame length", g_ch[0].last_len, 40);

        // Back-to-back 0x00, 0xFF, 0x3C.
        ena = 1'b0;
        push(8'h00); push(8'hFF); push(8'h3C);
        @(negedge clk);
        ena = 1'b1;
        wait_idle(1000, "b2b");
        check_both("b2b frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 4);
        check_both("b2b pop cycles", g_ch[0].rd_cycles, g_ch[1].rd_cycles, 4);
        check_both("b2b gaps checked", g_ch[0].n_gap, g_ch[1].n_gap, 2);

        // Parity byte 0x07.
        push(8'h07);
        wait_idle(500, "parity");
        check("ch1 parity frame length", g_ch[1].last_len, 44);
        check("ch0 plain frame length", g_ch[0].last_len, 40);

        // ena low with FIFO non-empty for 100 cycles.
        ena = 1'b0;
        rd0 = g_ch[0].rd_cycles; rd1 = g_ch[1].rd_cycles;
        st0 = g_ch[0].starts;    st1 = g_ch[1].starts;
        push(8'h96);
        bad0 = 0; bad1 = 0;
        repeat (100) begin
            @(negedge clk);
            if (g_ch[0].tx !== 1'b1) bad0++;
            if (g_ch[1].tx !== 1'b1) bad1++;
        end
        check_both("ena=0 tx low cycles", bad0, bad1, 0);
        check_both("ena=0 pops", g_ch[0].rd_cycles - rd0, g_ch[1].rd_cycles - rd1, 0);
        check_both("ena=0 starts", g_ch[0].starts - st0, g_ch[1].starts - st1, 0);
        ena = 1'b1;
        wait_idle(500, "ena release");

        // ena dropped mid-frame: frame completes, next byte stays queued.
        rd0 = g_ch[0].rd_cycles; rd1 = g_ch[1].rd_cycles;
        push(8'h11); push(8'h22);
        n = 0;
        do begin @(negedge clk); n++; end while (n < 100 && !g_ch[0].active);
        repeat (10) @(negedge clk);
        ena = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (n < 200 && (g_ch[0].active || g_ch[1].active || g_ch[0].busy || g_ch[1].busy));
        repeat (20) @(negedge clk);
        check_both("ena drop pops", g_ch[0].rd_cycles - rd0, g_ch[1].rd_cycles - rd1, 1);
        check_both("ena drop left in fifo", g_ch[0].fq.size(), g_ch[1].fq.size(), 1);
        check_both("ena drop frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 7);
        ena = 1'b1;
        wait_idle(500, "ena drop resume");
        check_both("resume frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 8);

        // FIFO drained externally while the transmitter sits in SETTLE.
        rd0 = g_ch[0].rd_cycles; rd1 = g_ch[1].rd_cycles;
        g_ch[0].fq.push_back(8'hC3);
        g_ch[1].fq.push_back(8'hC3);
        @(negedge clk);
        void'(g_ch[0].fq.pop_front());
        void'(g_ch[1].fq.pop_front());
        @(negedge clk);
        check_both("drain busy in settle", int'(g_ch[0].busy), int'(g_ch[1].busy), 1);
        check_both("drain fifo_read", int'(g_ch[0].fifo_read), int'(g_ch[1].fifo_read), 0);
        check_both("drain tx settle", int'(g_ch[0].tx), int'(g_ch[1].tx), 1);
        @(negedge clk);
        check_both("drain back to idle", int'(g_ch[0].busy), int'(g_ch[1].busy), 0);
        repeat (10) @(negedge clk);
        check_both("drain pops", g_ch[0].rd_cycles - rd0, g_ch[1].rd_cycles - rd1, 0);
        check_both("drain frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 8);

        // Reset asserted during data bit 3.
        push(8'h5A);
        n = 0;
        do begin @(negedge clk); n++; end while (n < 100 && !(g_ch[0].active && g_ch[0].cyc >= 18));
        check("ch0 reached data bit 3", int'(g_ch[0].active && g_ch[0].cyc == 18), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_both("async reset tx", int'(g_ch[0].tx), int'(g_ch[1].tx), 1);
        check_both("async reset busy", int'(g_ch[0].busy), int'(g_ch[1].busy), 0);
        check_both("async reset frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), 0);
        g_ch[0].fq.delete(); g_ch[1].fq.delete();
        g_ch[0].exp_q.delete(); g_ch[1].exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with ena toggling.
        rd0 = g_ch[0].rd_cycles; rd1 = g_ch[1].rd_cycles;
        n_push = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0 && g_ch[0].fq.size() < 6 && g_ch[1].fq.size() < 6) begin
                push(8'($urandom));
                n_push++;
            end
            if ($urandom_range(0, 29) == 0) ena = ~ena;
        end
        ena = 1'b1;
        wait_idle(5000, "random");
        check_both("random frame_count", int'(g_ch[0].frame_count), int'(g_ch[1].frame_count), n_push % 256);
        check_both("random pops", g_ch[0].rd_cycles - rd0, g_ch[1].rd_cycles - rd1, n_push);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..4095.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after data bit 7.
REQ-003 Port clk  input  1  sole clock; all state on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port ena  input  1  enable; low blocks new frames.
REQ-006 Port fifo_data  input  8  first-word-fall-through FIFO output word (registered inside FIFO, lags pointer by one cycle).
REQ-007 Port fifo_empty  input  1  FIFO empty flag.
REQ-008 Port fifo_read  output  1  one-cycle pop request to FIFO.
REQ-009 Port tx  output  1  serial line, idle high.
REQ-010 Port busy  output  1  high whenever state is not IDLE.
REQ-011 Port frame_count  output  8  completed frames, wraps 255->0.
REQ-012 One clock; reset is asynchronous and active-low, ports named clk and rst_n.

Function
REQ-013 States: IDLE, SETTLE, START, DATA, PARITY, STOP; encoding 3 bits.
REQ-014 IDLE -> SETTLE on edge where ena=1 and fifo_empty=0; else stay.
REQ-015 SETTLE lasts exactly one cycle; fifo_read=1 only in SETTLE, Moore-decoded from state.
REQ-016 At SETTLE-exit edge: capture fifo_data into 8-bit shift register, go to START.
REQ-017 The SETTLE cycle absorbs the FIFO's one-cycle output-register lag; capture never occurs earlier than 2 cycles after fifo_empty falls.
REQ-018 If fifo_empty=1 during SETTLE (external drain), fifo_read stays 0 and state returns to IDLE, no capture.
REQ-019 START drives tx=0 for CLKS_PER_BIT cycles.
REQ-020 DATA drives shift-register LSB first, bits 0..7, each CLKS_PER_BIT cycles; shift right on each bit boundary; 3-bit bit index.
REQ-021 PARITY (only if PARITY_EN=1) drives XOR of captured byte for CLKS_PER_BIT cycles; otherwise DATA -> STOP.
REQ-022 STOP drives tx=1 for CLKS_PER_BIT cycles, increments frame_count on exit, returns to IDLE.
REQ-023 Baud counter counts 0..CLKS_PER_BIT-1, cleared on every state entry; bit boundary when count = CLKS_PER_BIT-1.
REQ-024 tx is registered; tx=1 in IDLE and SETTLE.
REQ-025 Back-to-back frames: exactly 2 idle-high cycles (IDLE, SETTLE) between stop-bit end and next start bit.
REQ-026 ena falling mid-frame: current frame completes unchanged; no new SETTLE entry.
REQ-027 fifo_data changes outside the capture edge have no effect on tx.

Reset
REQ-028 rst_n low: state=IDLE, tx=1, fifo_read=0, busy=0, frame_count=0, baud counter=0, bit index=0, shift register=0.
REQ-029 Reset mid-frame aborts immediately; the line returns high asynchronously; the popped byte is lost.
REQ-030 After rst_n rises, first frame may start on the second clock edge at earliest.

Structure
REQ-031 Shared package fifo_uart_pkg holds the state enum type, STATE_W=3, DATA_W=8, default CLKS_PER_BIT.
REQ-032 One sub-module uart_baud_gen: parameterised counter with clear input and tick output; everything else in fifo_uart_tx.

Verification
REQ-033 CLKS_PER_BIT=4, FIFO holds 0xA5 -> fifo_read pulses once; tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles; frame_count=1.
REQ-034 FIFO holds 0x00,0xFF,0x3C -> three frames, exactly 2 high cycles between stop end and next start, frame_count=3, three fifo_read pulses.
REQ-035 PARITY_EN=1, byte 0x07 -> parity bit 1 after bit 7, frame 11 bits = 44 cycles.
REQ-036 ena=0 with FIFO non-empty -> tx stays 1, fifo_read never asserts for 100 cycles; ena dropped mid-frame -> frame completes, no next pop.
REQ-037 rst_n pulsed low during DATA bit 3 -> tx=1, busy=0 asynchronously; frame_count=0.
REQ-038 fifo_empty falls then rises before SETTLE exit -> no fifo_read, return to IDLE, tx stays 1.
